// File: rtl/serial_ripple_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
//   in_valid/in_ready + a, b, bin : operand channel (source -> subtractor)
//   out_valid/out_ready + diff, bout, ovf : result channel (subtractor -> sink)
// master: the side that sources operands and sinks results.
// slave : the subtractor itself.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin (mod 2^WIDTH),
// computed LSB first through a single subtract-with-borrow slice and a borrow
// flip-flop. One operation takes WIDTH cycles in BUSY; results are held in
// DONE until the sink takes them.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of serial_ripple_subtractor_if (operands in, result out)
module serial_ripple_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_ripple_subtractor_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b, res, diff_q;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb, bout_q, ovf_q;

  logic             a0, b0, bit_d, br_nx, last_bit;
  logic [WIDTH-1:0] res_nx;

  // Subtract-with-borrow slice on the current LSBs.
  assign a0       = sh_a[0];
  assign b0       = sh_b[0];
  assign bit_d    = a0 ^ b0 ^ br;
  assign br_nx    = (~a0 & b0) | (~(a0 ^ b0) & br);
  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_nx   = {bit_d, res[WIDTH-1:1]};
  assign last_bit = (cnt == LAST);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = BUSY;
      BUSY:    if (last_bit)      state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            br    <= bus.bin;
            cnt   <= '0;
            // Operand sign bits are shifted out during BUSY, keep them for ovf.
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
          end
        end
        BUSY: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= res_nx;
          br   <= br_nx;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            diff_q <= res_nx;
            bout_q <= br_nx;
            ovf_q  <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
